// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing BRAM port A between the load/store unit (m0) and the loader (m1).
// Optional macro BRAM_ARB_BYTE_EN adds per-byte write enables with a two-cycle read-modify-write.
module bram_port_arbiter #(
    parameter int unsigned DEPTH  = 16384,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 m0_req_i,
    input  logic                 m0_we_i,
    input  logic [ADDR_W-1:0]    m0_addr_i,
    input  logic [WIDTH-1:0]     m0_wdata_i,
`ifdef BRAM_ARB_BYTE_EN
    input  logic [WIDTH/8-1:0]   m0_be_i,
`endif
    output logic                 m0_gnt_o,
    output logic                 m0_rvalid_o,
    output logic [WIDTH-1:0]     m0_rdata_o,

    input  logic                 m1_req_i,
    input  logic                 m1_we_i,
    input  logic [ADDR_W-1:0]    m1_addr_i,
    input  logic [WIDTH-1:0]     m1_wdata_i,
`ifdef BRAM_ARB_BYTE_EN
    input  logic [WIDTH/8-1:0]   m1_be_i,
`endif
    output logic                 m1_gnt_o,
    output logic                 m1_rvalid_o,
    output logic [WIDTH-1:0]     m1_rdata_o,

    output logic                 bram_we_o,
    output logic [ADDR_W-1:0]    bram_addr_o,
    output logic [WIDTH-1:0]     bram_wdata_o,
    input  logic [WIDTH-1:0]     bram_rdata_i
);

`ifdef BRAM_ARB_BYTE_EN
    typedef enum logic [0:0] {StIdle, StRmwWr} state_e;
`else
    typedef enum logic [0:0] {StIdle} state_e;
`endif

    state_e state_q, state_d;

    // last_q is the index of the most recently granted requester
    logic last_q, last_d;
    logic rvalid_q, rvalid_d;
    logic owner_q, owner_d;

    logic              pick_valid;
    logic              pick1;
    logic              grant_ok;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [WIDTH-1:0]  sel_wdata;

`ifdef BRAM_ARB_BYTE_EN
    localparam int unsigned NumBytes = WIDTH / 8;

    logic                rmw_owner_q, rmw_owner_d;
    logic [NumBytes-1:0] sel_be;
    logic                sel_full;
    logic                sel_none;
    logic                sel_partial;
    logic [NumBytes-1:0] rmw_be;
    logic [ADDR_W-1:0]   rmw_addr;
    logic [WIDTH-1:0]    rmw_wdata;
    logic [WIDTH-1:0]    rmw_merged;
`endif

    // Round-robin pick: on a tie the requester not granted last wins.
    always_comb begin
        pick_valid = 1'b0;
        pick1      = 1'b0;
        if (m0_req_i && m1_req_i) begin
            pick_valid = 1'b1;
            pick1      = ~last_q;
        end else if (m0_req_i) begin
            pick_valid = 1'b1;
        end else if (m1_req_i) begin
            pick_valid = 1'b1;
            pick1      = 1'b1;
        end
    end

    always_comb begin
        sel_we    = pick1 ? m1_we_i    : m0_we_i;
        sel_addr  = pick1 ? m1_addr_i  : m0_addr_i;
        sel_wdata = pick1 ? m1_wdata_i : m0_wdata_i;
        grant_ok  = rst_ni && pick_valid && (state_q == StIdle);
    end

`ifdef BRAM_ARB_BYTE_EN
    always_comb begin
        sel_be      = pick1 ? m1_be_i : m0_be_i;
        sel_full    = &sel_be;
        sel_none    = ~|sel_be;
        sel_partial = ~sel_full && ~sel_none;

        // The RMW owner holds addr/wdata/be through the write cycle.
        rmw_be    = rmw_owner_q ? m1_be_i    : m0_be_i;
        rmw_addr  = rmw_owner_q ? m1_addr_i  : m0_addr_i;
        rmw_wdata = rmw_owner_q ? m1_wdata_i : m0_wdata_i;
        for (int i = 0; i < NumBytes; i++) begin
            rmw_merged[i*8 +: 8] = rmw_be[i] ? rmw_wdata[i*8 +: 8] : bram_rdata_i[i*8 +: 8];
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            last_q   <= 1'b1;
            rvalid_q <= 1'b0;
            owner_q  <= 1'b0;
`ifdef BRAM_ARB_BYTE_EN
            rmw_owner_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            rvalid_q <= rvalid_d;
            owner_q  <= owner_d;
`ifdef BRAM_ARB_BYTE_EN
            rmw_owner_q <= rmw_owner_d;
`endif
        end
    end

    always_comb begin
`ifdef BRAM_ARB_BYTE_EN
        state_d     = state_q;
        rmw_owner_d = rmw_owner_q;
        unique case (state_q)
            StIdle: begin
                if (grant_ok && sel_we && sel_partial) begin
                    state_d     = StRmwWr;
                    rmw_owner_d = pick1;
                end
            end
            StRmwWr: state_d = StIdle;
            default: state_d = StIdle;
        endcase
`else
        state_d = StIdle;
`endif
    end

    always_comb begin
        m0_gnt_o     = 1'b0;
        m1_gnt_o     = 1'b0;
        bram_we_o    = 1'b0;
        bram_addr_o  = m0_addr_i;
        bram_wdata_o = m0_wdata_i;
        last_d       = last_q;
        rvalid_d     = 1'b0;
        owner_d      = owner_q;

        if (grant_ok) begin
            m0_gnt_o     = ~pick1;
            m1_gnt_o     = pick1;
            last_d       = pick1;
            bram_addr_o  = sel_addr;
            bram_wdata_o = sel_wdata;
            rvalid_d     = ~sel_we;
            owner_d      = pick1;
`ifdef BRAM_ARB_BYTE_EN
            // Partial enables only read here; the merged write follows in StRmwWr.
            bram_we_o = sel_we && sel_full;
`else
            bram_we_o = sel_we;
`endif
        end
`ifdef BRAM_ARB_BYTE_EN
        else if (rst_ni && state_q == StRmwWr) begin
            bram_we_o    = 1'b1;
            bram_addr_o  = rmw_addr;
            bram_wdata_o = rmw_merged;
        end
`endif

        // Reset cancels a read return already in flight.
        m0_rvalid_o = rst_ni && rvalid_q && ~owner_q;
        m1_rvalid_o = rst_ni && rvalid_q && owner_q;
        m0_rdata_o  = m0_rvalid_o ? bram_rdata_i : '0;
        m1_rdata_o  = m1_rvalid_o ? bram_rdata_i : '0;
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed cases plus random traffic against a memory/round-robin model.
// Define BRAM_ARB_BYTE_EN consistently for bench and design to exercise byte enables.
module tb_bram_port_arbiter;

    localparam int unsigned Depth = 256;
    localparam int unsigned Width = 32;
    localparam int unsigned AddrW = $clog2(Depth);

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic             clk_i;
    logic             rst_ni;
    logic             m0_req, m0_we, m1_req, m1_we;
    logic [AddrW-1:0] m0_addr, m1_addr;
    logic [31:0]      m0_wdata, m1_wdata;
    logic             m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0]      m0_rdata, m1_rdata;
    logic             bram_we;
    logic [AddrW-1:0] bram_addr;
    logic [31:0]      bram_wdata, bram_rdata;
`ifdef BRAM_ARB_BYTE_EN
    logic [3:0]       m0_be, m1_be;
`endif

    bram_port_arbiter #(.DEPTH(Depth), .WIDTH(Width)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .m0_req_i    (m0_req),
        .m0_we_i     (m0_we),
        .m0_addr_i   (m0_addr),
        .m0_wdata_i  (m0_wdata),
`ifdef BRAM_ARB_BYTE_EN
        .m0_be_i     (m0_be),
`endif
        .m0_gnt_o    (m0_gnt),
        .m0_rvalid_o (m0_rvalid),
        .m0_rdata_o  (m0_rdata),
        .m1_req_i    (m1_req),
        .m1_we_i     (m1_we),
        .m1_addr_i   (m1_addr),
        .m1_wdata_i  (m1_wdata),
`ifdef BRAM_ARB_BYTE_EN
        .m1_be_i     (m1_be),
`endif
        .m1_gnt_o    (m1_gnt),
        .m1_rvalid_o (m1_rvalid),
        .m1_rdata_o  (m1_rdata),
        .bram_we_o   (bram_we),
        .bram_addr_o (bram_addr),
        .bram_wdata_o(bram_wdata),
        .bram_rdata_i(bram_rdata)
    );

    // BRAM port A: registered read, old data on same-cycle read-during-write.
    logic [31:0] bmem [64];
    always @(posedge clk_i) begin
        if (bram_we) bmem[bram_addr[7:2]] <= bram_wdata;
        bram_rdata <= bmem[bram_addr[7:2]];
    end

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Staged stimulus, applied at the next falling edge.
    logic        s_rst;
    logic        s_req   [2];
    logic        s_we    [2];
    logic [7:0]  s_addr  [2];
    logic [31:0] s_wdata [2];
    logic [3:0]  s_be    [2];

    // Reference model state.
    logic [31:0] ref_mem [64];
    int          last_gnt = 1;
    bit          rmw = 0;
    int          rmw_m = 0;
    bit          exp_g [2];
    exp_t        q0[$];
    exp_t        q1[$];

    task automatic set(input int m, input logic r, input logic w, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        s_req[m] = r; s_we[m] = w; s_addr[m] = a; s_wdata[m] = d; s_be[m] = be;
    endtask

    task automatic idle();
        s_req[0] = 1'b0;
        s_req[1] = 1'b0;
    endtask

    task automatic tick();
        int          w;
        bit          exp_we;
        logic [31:0] old, merged;
        exp_t        e;
        @(negedge clk_i);
        rst_ni   = s_rst;
        m0_req   = s_req[0]; m0_we = s_we[0]; m0_addr = s_addr[0]; m0_wdata = s_wdata[0];
        m1_req   = s_req[1]; m1_we = s_we[1]; m1_addr = s_addr[1]; m1_wdata = s_wdata[1];
`ifdef BRAM_ARB_BYTE_EN
        m0_be = s_be[0];
        m1_be = s_be[1];
`endif
        #1;
        exp_g[0] = 1'b0;
        exp_g[1] = 1'b0;
        exp_we   = 1'b0;
        if (!s_rst) begin
            last_gnt = 1;
            rmw      = 0;
            q0.delete();
            q1.delete();
        end
`ifdef BRAM_ARB_BYTE_EN
        else if (rmw) begin
            rmw    = 0;
            exp_we = 1'b1;
            old    = ref_mem[s_addr[rmw_m][7:2]];
            for (int b = 0; b < 4; b++)
                merged[8*b +: 8] = s_be[rmw_m][b] ? s_wdata[rmw_m][8*b +: 8] : old[8*b +: 8];
            chk("rmw bram_addr", 32'(bram_addr), 32'(s_addr[rmw_m]));
            chk("rmw bram_wdata", bram_wdata, merged);
            ref_mem[s_addr[rmw_m][7:2]] = merged;
        end
`endif
        else if (s_req[0] || s_req[1]) begin
            if (s_req[0] && s_req[1]) w = (last_gnt == 0) ? 1 : 0;
            else w = s_req[0] ? 0 : 1;
            exp_g[w] = 1'b1;
            last_gnt = w;
            chk("bram_addr", 32'(bram_addr), 32'(s_addr[w]));
            if (s_we[w]) begin
`ifdef BRAM_ARB_BYTE_EN
                if (s_be[w] == 4'hF) begin
                    exp_we = 1'b1;
                    chk("bram_wdata", bram_wdata, s_wdata[w]);
                    ref_mem[s_addr[w][7:2]] = s_wdata[w];
                end else if (s_be[w] != 4'h0) begin
                    rmw   = 1;
                    rmw_m = w;
                end
`else
                exp_we = 1'b1;
                chk("bram_wdata", bram_wdata, s_wdata[w]);
                ref_mem[s_addr[w][7:2]] = s_wdata[w];
`endif
            end else begin
                e.data = ref_mem[s_addr[w][7:2]];
                e.cyc  = cyc + 1;
                if (w == 0) q0.push_back(e);
                else q1.push_back(e);
            end
        end
        chk("m0_gnt", 32'(m0_gnt), 32'(exp_g[0]));
        chk("m1_gnt", 32'(m1_gnt), 32'(exp_g[1]));
        chk("bram_we", 32'(bram_we), 32'(exp_we));
    endtask

    // Monitor: read returns must land exactly one cycle after their grant.
    always @(negedge clk_i) begin
        exp_t e;
        #2;
        if (q0.size() > 0 && q0[0].cyc == cyc) begin
            e = q0.pop_front();
            chk("m0_rvalid", 32'(m0_rvalid), 32'd1);
            if (m0_rvalid) chk("m0_rdata", m0_rdata, e.data);
        end else begin
            chk("m0_rvalid", 32'(m0_rvalid), 32'd0);
        end
        if (q1.size() > 0 && q1[0].cyc == cyc) begin
            e = q1.pop_front();
            chk("m1_rvalid", 32'(m1_rvalid), 32'd1);
            if (m1_rvalid) chk("m1_rdata", m1_rdata, e.data);
        end else begin
            chk("m1_rvalid", 32'(m1_rvalid), 32'd0);
        end
        if (m1_rvalid) chk("m0_rdata non-owner", m0_rdata, 32'd0);
        if (m0_rvalid) chk("m1_rdata non-owner", m1_rdata, 32'd0);
    end

    initial begin
        bit   hold [2];
        logic [3:0] be;
        s_rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            set(m, 1'b0, 1'b0, 8'h00, 32'h0, 4'hF);
            hold[m] = 0;
        end
        repeat (3) tick();
        s_rst = 1'b1;

        // Single write then read-back on m0.
        set(0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF); tick();
        set(0, 1'b1, 1'b0, 8'h10, 32'h0, 4'hF);        tick();
        idle(); tick(); tick();

        // Preload every word so later reads have defined contents.
        for (int i = 0; i < 64; i++) begin
            set(0, 1'b1, 1'b1, 8'(i * 4), $urandom, 4'hF);
            tick();
        end
        idle(); s_rst = 1'b0; tick(); s_rst = 1'b1;

        // Both read for four cycles after reset: m0, m1, m0, m1.
        set(0, 1'b1, 1'b0, 8'h04, 32'h0, 4'hF);
        set(1, 1'b1, 1'b0, 8'h08, 32'h0, 4'hF);
        repeat (4) tick();
        idle(); tick(); s_rst = 1'b0; tick(); s_rst = 1'b1;

        // m1 write and m0 read on the same word in the same cycle, then m0 re-reads.
        set(0, 1'b1, 1'b0, 8'h20, 32'h0, 4'hF);
        set(1, 1'b1, 1'b1, 8'h20, 32'h11223344, 4'hF);
        tick();
        tick();
        s_req[1] = 1'b0;
        tick();
        idle(); tick(); tick();

        // Reset the cycle after a read grant, then a tie after release.
        set(0, 1'b1, 1'b0, 8'h40, 32'h0, 4'hF); tick();
        idle(); s_rst = 1'b0; tick(); tick(); s_rst = 1'b1;
        set(0, 1'b1, 1'b0, 8'h44, 32'h0, 4'hF);
        set(1, 1'b1, 1'b0, 8'h48, 32'h0, 4'hF);
        tick();
        idle(); tick(); tick();

`ifdef BRAM_ARB_BYTE_EN
        // Partial write RMW with m1 arriving during the write cycle.
        set(0, 1'b1, 1'b1, 8'h30, 32'hAABBCCDD, 4'hF); tick();
        set(0, 1'b1, 1'b1, 8'h30, 32'h000000EE, 4'b0001); tick();
        s_req[0] = 1'b0;
        set(1, 1'b1, 1'b0, 8'h30, 32'h0, 4'hF); tick();
        tick();
        idle(); tick();
        set(0, 1'b1, 1'b1, 8'h34, 32'h12345678, 4'h0); tick();
        set(0, 1'b1, 1'b0, 8'h34, 32'h0, 4'hF); tick();
        idle(); tick(); tick();
`endif

        // Random traffic with drops and occasional reset.
        for (int n = 0; n < 2000; n++) begin
            for (int m = 0; m < 2; m++) begin
                if (hold[m]) begin
                    s_req[m] = 1'b0;
                    hold[m]  = 0;
                end else begin
`ifdef BRAM_ARB_BYTE_EN
                    if (exp_g[m] && s_we[m] && s_be[m] != 4'hF && s_be[m] != 4'h0 && s_rst) begin
                        hold[m]  = 1;
                        s_req[m] = 1'b0;
                        continue;
                    end
`endif
                    if (!s_req[m] || exp_g[m]) begin
                        if ($urandom_range(0, 9) < 6) begin
                            case ($urandom_range(0, 3))
                                0:       be = 4'h0;
                                1:       be = 4'(($urandom_range(1, 14)));
                                default: be = 4'hF;
                            endcase
                            set(m, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7) * 4),
                                $urandom, be);
                        end else begin
                            s_req[m] = 1'b0;
                        end
                    end else if ($urandom_range(0, 19) == 0) begin
                        s_req[m] = 1'b0;
                    end
                end
            end
            s_rst = ($urandom_range(0, 199) != 0);
            tick();
        end

        s_rst = 1'b1;
        idle();
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
